// File: rtl/wired_fcc_iq.sv
// In-order issue queue for the FCC / FP-compare unit: buffers dispatched ops,
// captures operands from dispatch or wakeup, and issues only the oldest op.
module wired_fcc_iq #(
    parameter int DEPTH  = 4,
    parameter int INFO_W = 64,
    parameter int RID_W  = 6,
    parameter int WKUP_N = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    input  logic [INFO_W-1:0]         disp_info_i,
    input  logic [2*RID_W-1:0]        disp_rid_i,
    input  logic [1:0]                disp_rdy_i,
    input  logic [63:0]               disp_data_i,
    input  logic [WKUP_N-1:0]         wkup_valid_i,
    input  logic [WKUP_N*RID_W-1:0]   wkup_rid_i,
    input  logic [WKUP_N*32-1:0]      wkup_data_i,
    output logic                      ex_req_valid_o,
    input  logic                      ex_req_ready_i,
    output logic [INFO_W-1:0]         ex_req_info_o,
    output logic [31:0]               ex_req_r0_o,
    output logic [31:0]               ex_req_r1_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]                       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0]                    vld_q, vld_d;
    logic [DEPTH-1:0][1:0]               rdy_q, rdy_d;
    logic [DEPTH-1:0][1:0][RID_W-1:0]    rid_q, rid_d;
    logic [DEPTH-1:0][1:0][31:0]         opnd_q, opnd_d;
    logic [DEPTH-1:0][INFO_W-1:0]        info_q, info_d;

    logic [IW-1:0] widx, ridx;
    logic          full, disp_fire, iss_fire;

    assign widx      = wptr_q[IW-1:0];
    assign ridx      = rptr_q[IW-1:0];
    assign full      = (widx == ridx) && (wptr_q[IW] != rptr_q[IW]);
    assign disp_ready_o   = !full;
    assign disp_fire      = disp_valid_i && disp_ready_o;
    assign ex_req_valid_o = vld_q[ridx] && (&rdy_q[ridx]);
    assign iss_fire       = ex_req_valid_o && ex_req_ready_i;
    assign ex_req_info_o  = info_q[ridx];
    assign ex_req_r0_o    = opnd_q[ridx][0];
    assign ex_req_r1_o    = opnd_q[ridx][1];
    assign count_o        = wptr_q - rptr_q;

    // {hit, data}; scanning from the top port down lets the lowest index win.
    function automatic logic [32:0] wk_match(input logic [RID_W-1:0] tag);
        logic [32:0] r;
        r = '0;
        for (int k = WKUP_N - 1; k >= 0; k--) begin
            if (wkup_valid_i[k] && (wkup_rid_i[k*RID_W +: RID_W] == tag))
                r = {1'b1, wkup_data_i[k*32 +: 32]};
        end
        return r;
    endfunction

    always_comb begin
        logic [32:0] m;
        m      = '0;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        vld_d  = vld_q;
        rdy_d  = rdy_q;
        rid_d  = rid_q;
        opnd_d = opnd_q;
        info_d = info_q;

        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (vld_q[i] && !rdy_q[i][s]) begin
                    m = wk_match(rid_q[i][s]);
                    if (m[32]) begin
                        rdy_d[i][s]  = 1'b1;
                        opnd_d[i][s] = m[31:0];
                    end
                end
            end
        end

        if (iss_fire) begin
            vld_d[ridx] = 1'b0;
            rptr_d      = rptr_q + 1'b1;
        end

        // Same-cycle wakeup must be caught here or the broadcast is lost.
        if (disp_fire) begin
            vld_d[widx]  = 1'b1;
            info_d[widx] = disp_info_i;
            for (int s = 0; s < 2; s++) begin
                m = wk_match(disp_rid_i[s*RID_W +: RID_W]);
                rid_d[widx][s]  = disp_rid_i[s*RID_W +: RID_W];
                rdy_d[widx][s]  = disp_rdy_i[s] | m[32];
                opnd_d[widx][s] = disp_rdy_i[s] ? disp_data_i[s*32 +: 32] : m[31:0];
            end
            wptr_d = wptr_q + 1'b1;
        end

        if (flush_i) begin
            vld_d  = '0;
            rdy_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
            rdy_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            vld_q  <= vld_d;
            rdy_q  <= rdy_d;
        end
    end

    // Payload storage is qualified by the valid/ready bits, so it needs no reset.
    always_ff @(posedge clk) begin
        rid_q  <= rid_d;
        opnd_q <= opnd_d;
        info_q <= info_d;
    end
endmodule

// File: tb/tb_wired_fcc_iq.sv
// Scoreboard bench for wired_fcc_iq: stimulus pushes expected issue payloads,
// a negedge monitor pops and compares on every issue handshake.
module tb_wired_fcc_iq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_i = 1'b0;
    logic         disp_valid_i = 1'b0;
    logic         disp_ready_o;
    logic [63:0]  disp_info_i = '0;
    logic [11:0]  disp_rid_i = '0;
    logic [1:0]   disp_rdy_i = '0;
    logic [63:0]  disp_data_i = '0;
    logic [1:0]   wkup_valid_i = '0;
    logic [11:0]  wkup_rid_i = '0;
    logic [63:0]  wkup_data_i = '0;
    logic         ex_req_valid_o;
    logic         ex_req_ready_i = 1'b0;
    logic [63:0]  ex_req_info_o;
    logic [31:0]  ex_req_r0_o, ex_req_r1_o;
    logic [2:0]   count_o;

    int total = 0;
    int bad = 0;
    logic [127:0] sb[$];

    wired_fcc_iq dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_info_i(disp_info_i), .disp_rid_i(disp_rid_i),
        .disp_rdy_i(disp_rdy_i), .disp_data_i(disp_data_i),
        .wkup_valid_i(wkup_valid_i), .wkup_rid_i(wkup_rid_i), .wkup_data_i(wkup_data_i),
        .ex_req_valid_o(ex_req_valid_o), .ex_req_ready_i(ex_req_ready_i),
        .ex_req_info_o(ex_req_info_o), .ex_req_r0_o(ex_req_r0_o),
        .ex_req_r1_o(ex_req_r1_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush_i && ex_req_valid_o && ex_req_ready_i) begin
            logic [127:0] e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got info %h want none", ex_req_info_o);
            end else begin
                e = sb.pop_front();
                chk("issue_info", ex_req_info_o, e[127:64]);
                chk("issue_r0", {32'h0, ex_req_r0_o}, {32'h0, e[31:0]});
                chk("issue_r1", {32'h0, ex_req_r1_o}, {32'h0, e[63:32]});
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the op until accepted; exp_r0/exp_r1 are the operands it must issue with.
    task automatic disp(input logic [63:0] info, input logic [5:0] t1, input logic [5:0] t0,
                        input logic [1:0] rdy, input logic [31:0] d1, input logic [31:0] d0,
                        input logic [31:0] exp_r1, input logic [31:0] exp_r0);
        int n;
        n = 0;
        disp_valid_i = 1'b1;
        disp_info_i  = info;
        disp_rid_i   = {t1, t0};
        disp_rdy_i   = rdy;
        disp_data_i  = {d1, d0};
        forever begin
            @(negedge clk);
            if (disp_ready_o) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL disp_timeout: got ready 0 want 1");
                break;
            end
        end
        if (n <= 50) sb.push_back({info, exp_r1, exp_r0});
        @(posedge clk);
        #1;
        disp_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_valid", ex_req_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_disp_ready", disp_ready_o, 1);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // 1: single ready op, issue one cycle after dispatch
        ex_req_ready_i = 1'b1;
        disp(64'hA1, 6'd0, 6'd0, 2'b11, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000);
        @(negedge clk);
        chk("t1_valid", ex_req_valid_o, 1);
        chk("t1_count1", count_o, 1);
        cyc(1);
        @(negedge clk);
        chk("t1_count0", count_o, 0);
        chk("t1_valid0", ex_req_valid_o, 0);
        cyc(1);

        // 2: head blocked on r1 tag 5; younger ready op must wait
        disp(64'hA2, 6'd5, 6'd1, 2'b01, 32'h0, 32'h11111111, 32'h7FC00000, 32'h11111111);
        disp(64'hB2, 6'd2, 6'd3, 2'b11, 32'h22222222, 32'h33333333, 32'h22222222, 32'h33333333);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_blocked", ex_req_valid_o, 0);
            chk("t2_count", count_o, 2);
            cyc(1);
        end
        wkup_valid_i = 2'b10;
        wkup_rid_i   = {6'd5, 6'd0};
        wkup_data_i  = {32'h7FC00000, 32'h0};
        @(negedge clk);
        chk("t2_no_bypass", ex_req_valid_o, 0);
        cyc(1);
        wkup_valid_i = 2'b00;
        @(negedge clk);
        chk("t2_woken", ex_req_valid_o, 1);
        drain();

        // 3: fill, blocked dispatch during issue, then pointer wrap
        ex_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            disp(64'h300 + i, 6'd0, 6'd0, 2'b11, 32'h3100 + i, 32'h3000 + i, 32'h3100 + i, 32'h3000 + i);
        @(negedge clk);
        chk("t3_full_ready", disp_ready_o, 0);
        chk("t3_full_count", count_o, 4);
        cyc(1);
        ex_req_ready_i = 1'b1;
        disp_valid_i = 1'b1;
        @(negedge clk);
        chk("t3_issue_disp_ready", disp_ready_o, 0);
        for (int i = 0; i < 20; i++)
            disp(64'h400 + i, 6'd0, 6'd0, 2'b11, 32'h4100 + i, 32'h4000 + i, 32'h4100 + i, 32'h4000 + i);
        drain();
        @(negedge clk);
        chk("t3_count_end", count_o, 0);
        cyc(1);

        // 4: same-cycle wakeup on both ports, port 0 wins
        ex_req_ready_i = 1'b0;
        wkup_valid_i = 2'b11;
        wkup_rid_i   = {6'd9, 6'd9};
        wkup_data_i  = {32'hBBBB0001, 32'hAAAA0000};
        disp(64'hC4, 6'd4, 6'd9, 2'b10, 32'h44444444, 32'h0, 32'h44444444, 32'hAAAA0000);
        wkup_valid_i = 2'b00;
        @(negedge clk);
        chk("t4_issuable", ex_req_valid_o, 1);
        cyc(1);
        ex_req_ready_i = 1'b1;
        drain();

        // 5: flush with 3 queued and a concurrent dispatch
        ex_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            disp(64'h500 + i, 6'd0, 6'd0, 2'b11, 32'h0, 32'h5000 + i, 32'h0, 32'h5000 + i);
        flush_i = 1'b1;
        disp_valid_i = 1'b1;
        disp_info_i = 64'hDEAD;
        cyc(1);
        flush_i = 1'b0;
        disp_valid_i = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t5_count", count_o, 0);
        chk("t5_valid", ex_req_valid_o, 0);
        cyc(1);
        ex_req_ready_i = 1'b1;
        disp(64'h5F, 6'd0, 6'd0, 2'b11, 32'h5F01, 32'h5F00, 32'h5F01, 32'h5F00);
        drain();

        // 6: async reset with 2 pending
        ex_req_ready_i = 1'b0;
        disp(64'h600, 6'd0, 6'd0, 2'b11, 32'h61, 32'h60, 32'h61, 32'h60);
        disp(64'h601, 6'd0, 6'd0, 2'b11, 32'h63, 32'h62, 32'h63, 32'h62);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", ex_req_valid_o, 0);
        chk("t6_count", count_o, 0);
        chk("t6_disp_ready", disp_ready_o, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("t6_count_after", count_o, 0);
        ex_req_ready_i = 1'b1;
        disp(64'h6F, 6'd0, 6'd0, 2'b11, 32'h6F1, 32'h6F0, 32'h6F1, 32'h6F0);
        drain();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
